// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor. Each stage resolves one SEG-bit slice of the result.
// The operand bits that are still unused travel alongside in skew registers.
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);
  localparam int SEG = WIDTH / STAGES;

  logic adv;

  // Global stall: the whole pipe advances together, only when the output slot frees up.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int IW = WIDTH - gi * SEG;  // operand bits still to be summed
    localparam int LO = (gi + 1) * SEG;    // result bits resolved after this stage

    logic [IW-1:0]  a_in;
    logic [IW-1:0]  b_in;
    logic           v_in;
    logic           c_in;
    logic           s_in;
    logic [SEG:0]   seg_res;
    logic [LO-1:0]  sum_new;
    logic [LO-1:0]  sum_d;
    logic [LO-1:0]  sum_q;
    logic           v_d;
    logic           v_q;
    logic           c_d;
    logic           c_q;
    logic           s_d;
    logic           s_q;

    if (gi == 0) begin : g_src
      // Subtraction is A + ~B + 1: the +1 enters as the carry-in of the first slice.
      assign a_in    = in_a;
      assign b_in    = in_sub ? ~in_b : in_b;
      assign v_in    = in_valid;
      assign c_in    = in_sub;
      assign s_in    = in_sub;
      assign sum_new = seg_res[SEG-1:0];
    end else begin : g_src
      assign a_in    = g_stage[gi-1].g_skew.a_q;
      assign b_in    = g_stage[gi-1].g_skew.b_q;
      assign v_in    = g_stage[gi-1].v_q;
      assign c_in    = g_stage[gi-1].c_q;
      assign s_in    = g_stage[gi-1].s_q;
      assign sum_new = {seg_res[SEG-1:0], g_stage[gi-1].sum_q};
    end

    assign seg_res = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

    always_comb begin
      v_d   = v_q;
      c_d   = c_q;
      s_d   = s_q;
      sum_d = sum_q;
      if (adv) begin
        v_d   = v_in;
        c_d   = seg_res[SEG];
        s_d   = s_in;
        sum_d = sum_new;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= 1'b0;
        sum_q <= '0;
      end else begin
        v_q   <= v_d;
        c_q   <= c_d;
        s_q   <= s_d;
        sum_q <= sum_d;
      end
    end

    if (LO < WIDTH) begin : g_skew
      logic [WIDTH-LO-1:0] a_d;
      logic [WIDTH-LO-1:0] a_q;
      logic [WIDTH-LO-1:0] b_d;
      logic [WIDTH-LO-1:0] b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = a_in[IW-1:SEG];
          b_d = b_in[IW-1:SEG];
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  // For subtraction the top bit is the inverted carry, giving a WIDTH+1 two's-complement value.
  assign out_valid = g_stage[STAGES-1].v_q;
  assign out_sum   = {g_stage[STAGES-1].c_q ^ g_stage[STAGES-1].s_q, g_stage[STAGES-1].sum_q};

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, carry-split pipelined adder/subtractor with a valid/ready handshake on both sides.
- Successor to the fixed 16-bit two-stage adder buffer. Adds configurable width, configurable pipeline depth, add/sub mode per transaction, and backpressure.
- Sits between operand producers and the arithmetic consumers in the datapath.
- Sustains one result per cycle when the output is not stalled.

Parameters:
- WIDTH, 16, operand width in bits; must be divisible by STAGES.
- STAGES, 2, number of pipeline stages, equal to the number of carry-chain segments; range 1..WIDTH.

Ports:
- clock  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block accepts the transaction this cycle.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- in_sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  out_sum holds a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- out_sum  output  WIDTH+1  result.

Behaviour:
- Reset: asynchronous, active-high.
  - All stage valid bits, partial sums, delayed operands, carries and out_sum clear to 0.
  - While reset is asserted, out_valid=0.
  - in_ready=1 from the first edge after reset deasserts.
- Segmentation:
  - SEG = WIDTH/STAGES.
  - Stage k (k=0..STAGES-1) adds bits [k*SEG +: SEG] of A and B', plus the carry registered by stage k-1.
  - Stage 0 carry-in = in_sub.
  - B' = in_b when in_sub=0, ~in_b when in_sub=1.
  - Upper operand segments and mode bits are delayed alongside; lower result segments are carried forward. All of this forms skew registers.
- Result width rules:
  - Add: out_sum = {carry_out, sum}, which is exactly A+B.
  - Sub: out_sum = {~carry_out, diff}, which is exactly A-B as a (WIDTH+1)-bit two's-complement value.
  - Sub example: A<B gives MSB 1.
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid=1 with that result, given no stall.
- Throughput: one transaction per cycle.
- Handshake (global stall):
  - adv = ~out_valid | out_ready.
  - in_ready = adv, which depends combinationally on out_valid and out_ready only. It must not depend on in_valid.
  - When adv=1, every stage loads from its predecessor, and stage 0 loads {in_valid, operands}.
  - When adv=0, all stage registers hold. out_sum and out_valid stay stable until out_ready=1.
  - Bubbles (in_valid=0 while adv=1) propagate as valid=0 stages and consume no result slot.
  - Transfer occurs only on in_valid & in_ready, and on out_valid & out_ready.
- Data gating: data registers of invalid stages may hold stale values. out_sum is don't-care when out_valid=0, except after reset, where it is 0.
- Simultaneous events:
  - out_ready=1 and new in_valid=1 with a full pipeline: the result is drained and the new operand is accepted in the same cycle.
  - Reset mid-operation: all in-flight transactions are discarded with no output. The next transaction after reset starts cleanly.
- Overflow/wrap: none possible; the WIDTH+1 output holds every add or sub result exactly.
- STAGES=1 degenerates to a single registered full-width adder with latency 1.

Test Plan:
- Basic add (WIDTH=16, STAGES=2): A=199, B=1, sub=0, out_ready=1 -> out_valid exactly 2 cycles later with out_sum=200. Then A=199, B=100 -> 299. Then A=1990, B=183 -> 2173, on consecutive cycles.
- Sub and borrow: A=199, B=200, sub=1 -> out_sum=17'h1FFFF (-1). A=500, B=20, sub=1 -> 17'd480. A=0, B=16'hFFFF, sub=1 -> 17'h10001.
- Cross-segment carry (WIDTH=32, STAGES=4): A=32'hFFFF_FFFF, B=1 -> out_sum=33'h1_0000_0000 after 4 cycles. A=B=32'hFFFF_FFFF -> 33'h1_FFFF_FFFE.
- Backpressure: stream A=1..6, B=10 with out_ready=0 for cycles 3-6.
  - in_ready drops while out_valid=1 and out_ready=0; out_sum holds at 11.
  - After release, outputs 11..16 arrive in order, with none lost or duplicated.
- Bubbles and overlap: alternate in_valid 1/0 -> out_valid alternates with the same pattern, delayed by STAGES. With a full pipeline, out_ready=1 and in_valid=1 together sustain 100% throughput.
- Reset mid-flight: accept 2 transactions, assert reset asynchronously between edges -> out_valid=0 and out_sum=0 immediately, and no stale result appears after deassertion. The next transaction A=7, B=8 -> 15 at the correct latency.
